// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream controller.
package fifo_rd_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer: captures returning FIFO bytes and hands them out in order.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture,
  input  logic [DW-1:0] cap_data,
  input  logic          pop,
  output buf_state_t    occ,
  output logic          valid,
  output logic [DW-1:0] head
);

  buf_state_t    state, state_next;
  logic [DW-1:0] head_q, head_next;
  logic [DW-1:0] tail_q, tail_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      state  <= state_next;
      head_q <= head_next;
      tail_q <= tail_next;
    end
  end

  // The head register always holds the oldest byte; the tail only fills in TWO.
  always_comb begin
    state_next = state;
    head_next  = head_q;
    tail_next  = tail_q;
    unique case (state)
      EMPTY: begin
        if (capture) begin
          state_next = ONE;
          head_next  = cap_data;
        end
      end
      ONE: begin
        if (capture && pop) begin
          head_next = cap_data;
        end else if (capture) begin
          state_next = TWO;
          tail_next  = cap_data;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_next = ONE;
          head_next  = tail_q;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  assign occ   = state;
  assign valid = (state != EMPTY);
  assign head  = head_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the 8-bit synchronous FIFO into a valid/ready stream framed into PKT_LEN-byte packets.
// Optional accepted-byte counter port xfer_count is built when FIFO_RD_CNT_EN is defined.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int PKT_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [DW-1:0]    fifo_dout,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
`ifdef FIFO_RD_CNT_EN
  output logic [CNT_W-1:0] xfer_count,
`endif
  output logic             m_last
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  buf_state_t    occ;
  logic          rd_pending;
  logic          pop;
  logic [2:0]    credit;
  logic [BW-1:0] beat;

  assign pop = m_valid && m_ready;

  // Projected occupancy after this edge; a new pop is only issued if it will have a slot.
  assign credit     = {1'b0, occ} + {2'b00, rd_pending} - {2'b00, pop};
  assign fifo_rd_en = !rst && !fifo_empty && (credit < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= fifo_rd_en;
    end
  end

  fifo_rd_skid #(.DW(DW)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .capture  (rd_pending),
    .cap_data (fifo_dout),
    .pop      (pop),
    .occ      (occ),
    .valid    (m_valid),
    .head     (m_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
    end else if (pop) begin
      if (beat == LAST_BEAT) begin
        beat <= '0;
      end else begin
        beat <= beat + BW'(1);
      end
    end
  end

  assign m_last = (beat == LAST_BEAT);

`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (pop) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side controller for the team's 8-bit synchronous FIFO. It drains the FIFO through its `rd_en`/`empty`/`dout` interface, absorbs the FIFO's one-cycle registered read latency, and presents the bytes as a valid/ready stream. It also frames the stream into fixed-length packets with a `last` marker. It sits between the FIFO and any downstream consumer, such as a serializer or a bus master, and shares the FIFO's clock and reset.

## Interface
- `DW`, default 8: data width; must match the FIFO `dout` width.
- `PKT_LEN`, default 16: bytes per packet; legal range 2..256.
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `fifo_empty`, input, 1: FIFO empty flag, sampled in the current cycle.
- `fifo_dout`, input, DW: FIFO read data; valid in the cycle after an accepted `fifo_rd_en`.
- `fifo_rd_en`, output, 1: pop request to the FIFO; combinational.
- `m_valid`, output, 1: stream byte available.
- `m_ready`, input, 1: downstream accepts the byte.
- `m_data`, output, DW: stream byte.
- `m_last`, output, 1: final byte of the current packet.
- `xfer_count`, output, 16: accepted-byte counter; present only with `FIFO_RD_CNT_EN`.

## Operation
- **Buffer:** a 2-entry output buffer with states `EMPTY`, `ONE`, `TWO`, and a 1-bit `rd_pending` flag (a pop is in flight).
- **Pop rule:**
  - `fifo_rd_en = !fifo_empty && ((occ + rd_pending - pop) < 2)`, where `pop = m_valid && m_ready`.
  - `fifo_rd_en` is never asserted while `fifo_empty` is high.
  - Every `fifo_rd_en` pulse therefore removes exactly one FIFO entry.
- **Capture:** if `rd_pending` is set, `fifo_dout` is written into the buffer at the clock edge, and `rd_pending` takes the value of this cycle's `fifo_rd_en`.
- **Buffer transitions:**
  - `EMPTY`: on capture, go to `ONE`.
  - `ONE`: capture without pop, go to `TWO`; pop without capture, go to `EMPTY`; capture and pop together, stay in `ONE`.
  - `TWO`: on pop, go to `ONE`. Capture in `TWO` cannot occur because the credit rule forbids it; this is asserted in the bench.
- **Output:** the head entry drives `m_data`. `m_valid = (occ != 0)`, decoded from the registered state.
- **Ordering:** bytes leave in FIFO order with no loss and no duplication.
- **Stream rules:**
  - While `m_valid && !m_ready`, `m_data` and `m_last` stay stable.
  - `m_valid` does not drop until the byte is accepted.
- **Packet framing:**
  - A beat counter of width `$clog2(PKT_LEN)` increments on each `pop`.
  - `m_last` is high when `beat == PKT_LEN-1`.
  - The counter wraps to 0 on the pop of the last byte.
- **Reset:**
  - All state clears asynchronously: `occ = EMPTY`, `rd_pending = 0`, `beat = 0`, buffer contents 0.
  - The outputs `m_valid`, `m_data`, `m_last` and `xfer_count` go to 0 immediately.
  - `fifo_rd_en` is forced low while `rst` is high.
  - A byte in flight during reset is discarded. The FIFO resets on the same `rst`, so no entry is orphaned.

## Timing
- **First-byte latency:**
  - `fifo_empty` falls in cycle N while the buffer is empty, so `fifo_rd_en` is high in cycle N.
  - `fifo_dout` is valid in cycle N+1 and is captured at the end of N+1.
  - `m_valid` rises in cycle N+2, two cycles after `fifo_empty` fell.
- **Throughput:** with `m_ready` held high and the FIFO non-empty, one byte per cycle is sustained after the first byte.
- **Backpressure:** at most 2 bytes are buffered or in flight. After `m_ready` falls, at most one further pop is issued.
- **Combinational path:** the only combinational input-to-output path is `m_ready`/`fifo_empty` to `fifo_rd_en`. `m_valid`, `m_data` and `m_last` are register outputs.

## Configuration
- **`FIFO_RD_CNT_EN` defined:**
  - The `xfer_count` port and a 16-bit counter are present.
  - The counter increments on each `pop` and wraps from 65535 to 0.
  - It is cleared by `rst`.
- **`FIFO_RD_CNT_EN` not defined:** the port and counter are absent, and all other behaviour is identical.

## Structure
- **Package `fifo_rd_pkg`:**
  - the `DW` default;
  - the buffer-state enum (`EMPTY`, `ONE`, `TWO`);
  - the 16-bit counter width constant.
- **Sub-module `fifo_rd_skid`:** the 2-entry buffer with its occupancy state, capture and pop logic. The top level holds the pop rule, `rd_pending`, the beat counter and the optional transfer counter.

## Test plan
- **Single byte:** the FIFO holds 0xA5 and `m_ready` is high. Expect `fifo_rd_en` as a 1-cycle pulse, then `m_valid` with `m_data = 0xA5` two cycles after `fifo_empty` fell. `m_last` is 0, and `m_valid` is low on the following cycle.
- **Streaming and framing:** 32 bytes 0x00..0x1F with `m_ready` always high. Expect 32 consecutive accepted beats in order. `m_last` is high only on 0x0F and 0x1F. With `FIFO_RD_CNT_EN`, `xfer_count` ends at 32.
- **Backpressure:** 8 bytes with `m_ready` toggled 1,0,0,1,… Expect all 8 bytes in order, no more than 2 bytes buffered or in flight, and `m_data` stable while stalled.
- **Empty gaps:** the FIFO is refilled one byte at a time with 3-cycle gaps. Expect `fifo_rd_en` never high while `fifo_empty` is high, and no duplicate bytes.
- **Reset mid-packet:** assert `rst` asynchronously after 5 bytes of a packet have been accepted, with a pop in flight. Expect `m_valid = 0` and `fifo_rd_en = 0` at once, and `xfer_count = 0`. After release, the next packet starts at `beat = 0` and `m_last` falls on its 16th byte.
- **Counter wrap (`FIFO_RD_CNT_EN`):** 65537 bytes transferred. Expect `xfer_count = 1`.
